// File: rtl/multi_chan_debounce.sv
// Multi-channel input debouncer.
// Each channel passes through a SYNC_STAGES-deep synchroniser and is then
// filtered either by a shared periodic sampler (MODE 0) or by a per-channel
// stable-count filter (MODE 1). Registered rise/fall strobes accompany every
// change of data_out so downstream logic needs no edge detectors of its own.
module multi_chan_debounce #(
   parameter int                  CHANNELS     = 4,
   parameter int                  SYNC_STAGES  = 4,
   parameter int                  CNT_WIDTH    = 21,
   parameter int                  STABLE_COUNT = 5,
   parameter int                  MODE         = 1,
   parameter logic [CHANNELS-1:0] PRESET_VAL   = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] data_in,
   output logic [CHANNELS-1:0] data_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   // Counter constants, truncated to the counter width.
   localparam logic [CNT_WIDTH-1:0] PERIOD_RELOAD = CNT_WIDTH'(STABLE_COUNT);
   localparam logic [CNT_WIDTH-1:0] ACCEPT_AT     = CNT_WIDTH'(STABLE_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1);

   // Synchroniser stages; index 0 captures the raw pins.
   logic [CHANNELS-1:0]  sync_chain [SYNC_STAGES];
   logic [CHANNELS-1:0]  sync;
   // Shared sample-period counter (MODE 0).
   logic [CNT_WIDTH-1:0] period_cnt;
   // Per-channel persistence counters (MODE 1).
   logic [CNT_WIDTH-1:0] stable_cnt [CHANNELS];

   assign sync = sync_chain[SYNC_STAGES-1];

   // Synchroniser, filter counters, debounced levels and edge strobes.
   // The chain resets to PRESET_VAL so the filter sees no change on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_chain[s] <= PRESET_VAL;
         end
         period_cnt <= PERIOD_RELOAD;
         for (int i = 0; i < CHANNELS; i++) begin
            stable_cnt[i] <= '0;
         end
         data_out <= PRESET_VAL;
         rise     <= '0;
         fall     <= '0;
      end else begin
         sync_chain[0] <= data_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_chain[s] <= sync_chain[s-1];
         end

         // Strobes default low; only an accepted change raises one.
         rise <= '0;
         fall <= '0;

         if (MODE == 0) begin
            // Legacy mode: all channels sampled together once per period.
            if (period_cnt == '0) begin
               data_out   <= sync;
               rise       <= sync & ~data_out;
               fall       <= ~sync & data_out;
               period_cnt <= PERIOD_RELOAD;
            end else begin
               period_cnt <= period_cnt - CNT_ONE;
            end
         end else begin
            // Stable-count mode: a new level must persist STABLE_COUNT
            // consecutive cycles; any return to the old level restarts it.
            for (int i = 0; i < CHANNELS; i++) begin
               if (sync[i] == data_out[i]) begin
                  stable_cnt[i] <= '0;
               end else if (stable_cnt[i] == ACCEPT_AT) begin
                  data_out[i]   <= sync[i];
                  rise[i]       <= sync[i];
                  fall[i]       <= ~sync[i];
                  stable_cnt[i] <= '0;
               end else begin
                  stable_cnt[i] <= stable_cnt[i] + CNT_ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_chan_debounce.sv
// Testbench for multi_chan_debounce: three instances (stable-count with zero
// preset, stable-count with preset 4'b0101, periodic sampler) checked every
// cycle against a timestamp-based reference model plus directed scenarios.
module tb_multi_chan_debounce;

   localparam int SYNC  = 4;
   localparam int STAB  = 5;
   localparam int LOG_N = 8192;

   logic       clk;
   logic       rst_n;
   logic [3:0] din   [3];
   logic [3:0] dout  [3];
   logic [3:0] drise [3];
   logic [3:0] dfall [3];

   int n_chk;
   int n_fail;

   // Reference model state.
   int         ecnt;
   logic [3:0] din_log [3][LOG_N];
   logic [3:0] m_out  [3];
   logic [3:0] m_rise [3];
   logic [3:0] m_fall [3];
   int         last_ok [3][4];
   logic [3:0] m_s;
   logic [3:0] m_nxt;

   // Directed-test helpers.
   logic mon_c;
   logic prev_c1;
   int   chg_c;
   int   rise_j;
   int   fall_j;
   int   n_r;
   int   n_f;
   int   hit;

   multi_chan_debounce #(.CHANNELS(4), .SYNC_STAGES(SYNC), .CNT_WIDTH(21), .STABLE_COUNT(STAB),
                         .MODE(1), .PRESET_VAL(4'b0000)) u_a (
      .clk(clk), .rst_n(rst_n), .data_in(din[0]), .data_out(dout[0]), .rise(drise[0]), .fall(dfall[0]));

   multi_chan_debounce #(.CHANNELS(4), .SYNC_STAGES(SYNC), .CNT_WIDTH(21), .STABLE_COUNT(STAB),
                         .MODE(1), .PRESET_VAL(4'b0101)) u_b (
      .clk(clk), .rst_n(rst_n), .data_in(din[1]), .data_out(dout[1]), .rise(drise[1]), .fall(dfall[1]));

   multi_chan_debounce #(.CHANNELS(4), .SYNC_STAGES(SYNC), .CNT_WIDTH(21), .STABLE_COUNT(STAB),
                         .MODE(0), .PRESET_VAL(4'b0000)) u_c (
      .clk(clk), .rst_n(rst_n), .data_in(din[2]), .data_out(dout[2]), .rise(drise[2]), .fall(dfall[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] pre_of(input int k);
      return (k == 1) ? 4'b0101 : 4'b0000;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the filtered level follows the synchronised input
   // (raw input seen SYNC edges earlier). Stable-count: a new level is
   // accepted once it has differed from the output for STAB consecutive edges
   // since the last edge where it matched. Periodic: sample every STAB+1 edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ecnt = 0;
         for (int k = 0; k < 3; k++) begin
            m_out[k]  = pre_of(k);
            m_rise[k] = 4'b0;
            m_fall[k] = 4'b0;
            for (int i = 0; i < 4; i++) last_ok[k][i] = 0;
         end
      end else begin
         ecnt++;
         for (int k = 0; k < 3; k++) begin
            if (ecnt < LOG_N) din_log[k][ecnt] = din[k];
            m_s   = (ecnt > SYNC && ecnt - SYNC < LOG_N) ? din_log[k][ecnt-SYNC] : pre_of(k);
            m_nxt = m_out[k];
            if (k == 2) begin
               if (ecnt % (STAB + 1) == 0) m_nxt = m_s;
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (m_s[i] == m_out[k][i]) begin
                     last_ok[k][i] = ecnt;
                  end else if (ecnt - last_ok[k][i] >= STAB) begin
                     m_nxt[i]      = m_s[i];
                     last_ok[k][i] = ecnt;
                  end
               end
            end
            m_rise[k] = m_nxt & ~m_out[k];
            m_fall[k] = ~m_nxt & m_out[k];
            m_out[k]  = m_nxt;
         end
      end
   end

   // Continuous comparison of every instance against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("out%0d", k),  dout[k],  m_out[k]);
         check_val($sformatf("rise%0d", k), drise[k], m_rise[k]);
         check_val($sformatf("fall%0d", k), dfall[k], m_fall[k]);
      end
   end

   // Periodic-mode change monitor for channel 1 of the sampler instance.
   always @(negedge clk) begin
      if (mon_c && dout[2][1] !== prev_c1) begin
         chg_c++;
         check_val("c_period", ecnt % (STAB + 1), 0);
         check_val("c_pulse", {drise[2][1], dfall[2][1]}, dout[2][1] ? 2'b10 : 2'b01);
      end
      prev_c1 = dout[2][1];
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      mon_c   = 1'b0;
      prev_c1 = 1'b0;
      chg_c   = 0;
      rst_n   = 1'b0;
      din[0]  = 4'b0000;
      din[1]  = 4'b0101;
      din[2]  = 4'b0000;

      // Reset state and quiet hold with preset 4'b0101.
      repeat (3) @(negedge clk);
      check_val("rst_out_b", dout[1], 4'b0101);
      check_val("rst_out_a", dout[0], 4'b0000);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 50; j++) begin
         @(negedge clk);
         check_val("hold_out_b", dout[1], 4'b0101);
         check_val("hold_edge_b", {drise[1], dfall[1]}, 8'h00);
      end

      // Clean step on channel 0: accepted on the 9th edge, one-cycle strobe.
      din[0] = 4'b0001;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j < 9) begin
            check_val("step_wait", dout[0], 4'b0000);
         end else if (j == 9) begin
            check_val("step_out", dout[0], 4'b0001);
            check_val("step_rise", drise[0], 4'b0001);
            check_val("step_fall", dfall[0], 4'b0000);
         end else begin
            check_val("step_rise_end", drise[0], 4'b0000);
         end
      end

      // Short glitch (4 cycles) on channel 2 is rejected.
      din[0][2] = 1'b1;
      repeat (4) @(negedge clk);
      din[0][2] = 1'b0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         check_val("glitch_out", dout[0][2], 1'b0);
         check_val("glitch_rise", drise[0][2], 1'b0);
      end

      // 5-cycle pulse on channel 2: accepted, then released 5 cycles later.
      n_r = 0; n_f = 0; rise_j = 0; fall_j = 0;
      din[0][2] = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         if (drise[0][2]) begin n_r++; rise_j = j; end
         if (dfall[0][2]) begin n_f++; fall_j = j; end
         if (j == 5) din[0][2] = 1'b0;
      end
      check_val("pulse_nrise", n_r, 1);
      check_val("pulse_nfall", n_f, 1);
      check_val("pulse_rise_at", rise_j, 9);
      check_val("pulse_fall_at", fall_j, 14);

      // All four channels rising together.
      din[0] = 4'b0000;
      repeat (20) @(negedge clk);
      din[0] = 4'b1111;
      hit = 0;
      for (int j = 1; j <= 20 && hit == 0; j++) begin
         @(negedge clk);
         if (dout[0] != 4'b0000) begin
            hit = j;
            check_val("all_out", dout[0], 4'b1111);
            check_val("all_rise", drise[0], 4'b1111);
         end
      end
      check_val("all_latency", hit, 9);

      // Periodic sampler: channel 1 toggling every 12 cycles.
      repeat (2) @(negedge clk);
      mon_c = 1'b1;
      for (int t = 0; t < 10; t++) begin
         din[2][1] = ~din[2][1];
         repeat (12) @(negedge clk);
      end
      repeat (30) @(negedge clk);
      mon_c = 1'b0;
      check_val("c_changes", chg_c, 10);

      // Reset while channel 3 has a pending count of 3.
      din[0] = 4'b0000;
      repeat (20) @(negedge clk);
      din[0][3] = 1'b1;
      repeat (7) @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_rst_out", dout[0], 4'b0000);
      check_val("mid_rst_rise", drise[0], 4'b0000);
      #1 rst_n = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (j < 9) begin
            check_val("post_rst_wait", dout[0][3], 1'b0);
            check_val("post_rst_rise", drise[0][3], 1'b0);
         end else begin
            check_val("post_rst_out", dout[0][3], 1'b1);
            check_val("post_rst_rise9", drise[0][3], 1'b1);
         end
      end

      // Randomised stimulus with a mid-run reset pulse.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
               if ($urandom_range(4) == 0) din[k][i] = ~din[k][i];
            end
         end
         if (c == 700) #1 rst_n = 1'b0;
         if (c == 703) #1 rst_n = 1'b1;
      end
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
